direction_input: RTL and testbench
==================================

DIRECTION_INPUT -- requirements
Module: direction_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000; the number of consecutive stable synchronized cycles before a key change is accepted (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter KEY_ACTIVE_LOW, default 1; 1 means iKEY bit = 0 is pressed, 0 means iKEY bit = 1 is pressed.
REQ-003 SHALL have port iCLK, input, 1 bit; the single clock, 50 MHz system clock, all logic on the rising edge.
REQ-004 SHALL have port iRSTn, input, 1 bit; reset, synchronous and active-low.
REQ-005 SHALL have port iKEY, input, 4 bits; raw asynchronous pushbuttons: [0] up, [1] down, [2] left, [3] right.
REQ-006 SHALL have port data_x, output, 2 bits, registered; [1] = horizontal move active, [0] = direction (1 right, 0 left).
REQ-007 SHALL have port data_y, output, 2 bits, registered; [1] = vertical move active, [0] = direction (1 up, 0 down).
REQ-008 SHALL have port oKEY_STATE, output, 4 bits, registered; debounced pressed state per key (1 = pressed), same bit order as iKEY.

Function
REQ-009 SHALL pass each iKEY bit through a 2-flop synchronizer, then convert it to active-high per KEY_ACTIVE_LOW.
REQ-010 SHALL keep one debounce counter per key, width clog2(DEBOUNCE_CYCLES); the counter clears whenever the synchronized level equals the debounced state.
REQ-011 SHALL increment the key's counter each cycle the synchronized level differs from its debounced state.
REQ-012 SHALL, on the cycle the counter equals DEBOUNCE_CYCLES-1 while still differing, toggle the debounced state and clear the counter.
REQ-013 SHALL produce no debounced change from a synchronized pulse shorter than DEBOUNCE_CYCLES cycles, because the counter restarts from 0 on every bounce.
REQ-014 SHALL give a key held stable a latency of exactly 2 + DEBOUNCE_CYCLES + 1 cycles from the iKEY edge to the data_x/data_y/oKEY_STATE change.
REQ-015 SHALL hold a last-pressed register per axis: last_x (1 right, 0 left), last_y (1 up, 0 down).
REQ-016 SHALL update last_x/last_y on the debounced rising edge of a key: right → last_x=1, left → last_x=0, up → last_y=1, down → last_y=0.
REQ-017 SHALL, when both keys of one axis rise in the same cycle, set right (last_x=1) and up (last_y=1) respectively.
REQ-018 SHALL encode the horizontal output as: neither key = 2'b00; left only = 2'b10; right only = 2'b11; both = {1'b1, last_x}.
REQ-019 SHALL encode the vertical output the same way: neither = 2'b00; down only = 2'b10; up only = 2'b11; both = {1'b1, last_y}.
REQ-020 SHALL register data_x, data_y and oKEY_STATE one cycle after the debounced/last_* state; no combinational path from iKEY to any output.
REQ-021 SHALL encode the horizontal and vertical axes independently, so any horizontal+vertical combination (e.g. right+down = data_x 11, data_y 10) is produced.
REQ-022 SHALL leave last_x/last_y unchanged on a key release; releasing the later key of a held pair reverts the output to the still-held key's direction.

Reset
REQ-023 SHALL, on a rising edge of iCLK with iRSTn = 0, set synchronizers to "released", all debounced states to 0, all counters to 0, last_x = 1, last_y = 1, and data_x = data_y = 2'b00, oKEY_STATE = 4'b0000.
REQ-024 SHALL restart from the released state on reset asserted mid-debounce or with keys held; a held key is re-accepted only after the full REQ-014 latency following reset release.

Verification (DEBOUNCE_CYCLES = 4, KEY_ACTIVE_LOW = 1)
REQ-025 Reset then idle (iKEY = 4'b1111) → data_x = 00, data_y = 00, oKEY_STATE = 0000 on every cycle.
REQ-026 iKEY[3] driven to 0 and held → data_x = 11 and oKEY_STATE = 1000 exactly 7 cycles after the edge, unchanged before that.
REQ-027 iKEY[2] low for 3 cycles, then high, repeated 5 times → data_x stays 00 throughout.
REQ-028 Hold left; 20 cycles later also hold right → data_x 10 then 11. Release right → data_x returns to 10 within 7 cycles.
REQ-029 Press up and down in the same cycle → data_y = 11. Press right+down only → data_x = 11, data_y = 10.
REQ-030 Hold up until data_y = 11, assert iRSTn = 0 for 1 cycle while still holding → outputs 00 on the next edge, data_y = 11 again 7 cycles after reset release.

Source files
------------

// File: rtl/direction_input.sv
// Four-key direction pad: synchronizes and debounces raw pushbuttons, then encodes
// per-axis move/direction with last-pressed priority when both keys of an axis are held.
module direction_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       iCLK,
  input  logic       iRSTn,
  input  logic [3:0] iKEY,
  output logic [1:0] data_x,
  output logic [1:0] data_y,
  output logic [3:0] oKEY_STATE
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      RELEASED = KEY_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

  logic [3:0]       sync1, sync2;
  logic [3:0]       key_level;
  logic [3:0]       deb, deb_next, done, rise;
  logic [CNT_W-1:0] cnt [4];
  logic             last_x, last_y;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    key_level = KEY_ACTIVE_LOW ? ~sync2 : sync2;
    deb_next  = deb;
    done      = '0;
    for (int i = 0; i < 4; i++) begin
      done[i] = (key_level[i] != deb[i]) && (cnt[i] == CNT_LAST);
      if (done[i]) deb_next[i] = ~deb[i];
    end
    rise = deb_next & ~deb;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      sync1      <= RELEASED;
      sync2      <= RELEASED;
      deb        <= '0;
      // NOTE: the counter array is small per-key state, not a RAM, so it is
      // reset explicitly element by element.
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      last_x     <= 1'b1;
      last_y     <= 1'b1;
      data_x     <= 2'b00;
      data_y     <= 2'b00;
      oKEY_STATE <= 4'b0000;
    end else begin
      sync1 <= iKEY;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (key_level[i] == deb[i] || done[i]) cnt[i] <= '0;
        else                                   cnt[i] <= cnt[i] + CNT_W'(1);
      end
      deb <= deb_next;

      // Right and up win when both keys of an axis are accepted together.
      if (rise[RIGHT])     last_x <= 1'b1;
      else if (rise[LEFT]) last_x <= 1'b0;
      if (rise[UP])        last_y <= 1'b1;
      else if (rise[DOWN]) last_y <= 1'b0;

      oKEY_STATE <= deb;
      data_x     <= {deb[LEFT] | deb[RIGHT], deb[RIGHT] & (~deb[LEFT] | last_x)};
      data_y     <= {deb[UP] | deb[DOWN],    deb[UP]    & (~deb[DOWN] | last_y)};
    end
  end

endmodule

// File: tb/tb_direction_input.sv
// Directed bench for direction_input: stimulus queues each expected output change with
// its arrival cycle; a negedge monitor pops and compares on every observed output change.
module tb_direction_input;

  localparam int D   = 4;
  localparam int LAT = 2 + D + 1;

  logic       iCLK = 1'b0;
  logic       iRSTn;
  logic [3:0] iKEY;
  logic [1:0] data_x, data_y;
  logic [3:0] oKEY_STATE;

  direction_input #(.DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b1)) dut (
    .iCLK      (iCLK),
    .iRSTn     (iRSTn),
    .iKEY      (iKEY),
    .data_x    (data_x),
    .data_y    (data_y),
    .oKEY_STATE(oKEY_STATE)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp_v);
    end
  endtask

  function automatic logic [7:0] val(input logic [1:0] x, input logic [1:0] y, input logic [3:0] k);
    return {x, y, k};
  endfunction

  // Monitor: any change of {data_x,data_y,oKEY_STATE} must match the next queued entry.
  always @(negedge iCLK) begin
    logic [7:0] cur;
    exp_t       e;
    if (mon_en) begin
      cur = {data_x, data_y, oKEY_STATE};
      if (cur !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got %b at cycle %0d, want no change", cur, cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_val"}, 32'(cur), 32'(e.val));
          check({e.name, "_cyc"}, 32'(cyc), 32'(e.cyc));
        end
        prev = cur;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic [7:0] v, input string nm);
    iKEY = k;
    sb.push_back('{cyc: cyc + LAT, val: v, name: nm});
  endtask

  initial begin
    iRSTn = 1'b0;
    iKEY  = 4'b1111;
    step(3);
    check("reset_state", 32'({data_x, data_y, oKEY_STATE}), 32'd0);
    iRSTn  = 1'b1;
    prev   = 8'd0;
    mon_en = 1'b1;
    step(10);

    // Single right press and release
    drive(4'b0111, val(2'b11, 2'b00, 4'b1000), "right_press");   step(10);
    drive(4'b1111, val(2'b00, 2'b00, 4'b0000), "right_release"); step(10);

    // Left bouncing with 3-cycle pulses never gets accepted
    repeat (5) begin
      iKEY[2] = 1'b0; step(3);
      iKEY[2] = 1'b1; step(3);
    end
    step(10);

    // Left held, then right added, right released, left released
    drive(4'b1011, val(2'b10, 2'b00, 4'b0100), "left_hold");     step(20);
    drive(4'b0011, val(2'b11, 2'b00, 4'b1100), "left_right");    step(10);
    drive(4'b1011, val(2'b10, 2'b00, 4'b0100), "right_off");     step(10);
    drive(4'b1111, val(2'b00, 2'b00, 4'b0000), "left_off");      step(10);

    // Right held, then left added: left is most recent
    drive(4'b0111, val(2'b11, 2'b00, 4'b1000), "right_hold");    step(10);
    drive(4'b0011, val(2'b10, 2'b00, 4'b1100), "right_left");    step(10);
    drive(4'b0111, val(2'b11, 2'b00, 4'b1000), "left_off2");     step(10);
    drive(4'b1111, val(2'b00, 2'b00, 4'b0000), "right_off2");    step(10);

    // Up and down together: up wins
    drive(4'b1100, val(2'b00, 2'b11, 4'b0011), "up_down_same");  step(10);
    drive(4'b1111, val(2'b00, 2'b00, 4'b0000), "up_down_off");   step(10);

    // Up held, then down added, then down released
    drive(4'b1110, val(2'b00, 2'b11, 4'b0001), "up_hold");       step(10);
    drive(4'b1100, val(2'b00, 2'b10, 4'b0011), "up_then_down");  step(10);
    drive(4'b1110, val(2'b00, 2'b11, 4'b0001), "down_off");      step(10);
    drive(4'b1111, val(2'b00, 2'b00, 4'b0000), "up_off");        step(10);

    // Independent axes: right + down
    drive(4'b0101, val(2'b11, 2'b10, 4'b1010), "right_down");    step(10);
    drive(4'b1111, val(2'b00, 2'b00, 4'b0000), "rd_off");        step(10);

    // Reset for one cycle while up is held, then re-acceptance
    drive(4'b1110, val(2'b00, 2'b11, 4'b0001), "rst_up");        step(10);
    iRSTn = 1'b0;
    sb.push_back('{cyc: cyc + 1, val: 8'd0, name: "rst_assert"});
    step(1);
    iRSTn = 1'b1;
    sb.push_back('{cyc: cyc + LAT, val: val(2'b00, 2'b11, 4'b0001), name: "rst_reaccept"});
    step(10);
    drive(4'b1111, val(2'b00, 2'b00, 4'b0000), "rst_up_off");    step(12);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
